// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU (master 0) and LSU (master 1); define MEM_ARB_RR_EN for round-robin arbitration
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        m_req_valid,
  output logic [1:0]        m_req_ready,
  input  logic [2*AW-1:0]   m_addr,
  input  logic [2*DW-1:0]   m_wdata,
  input  logic [2*DW/8-1:0] m_wmask,
  input  logic [1:0]        m_wen,
  output logic [1:0]        m_rsp_valid,
  input  logic [1:0]        m_rsp_ready,
  output logic [DW-1:0]     m_rdata,
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  output logic [DW/8-1:0]   s_wmask,
  output logic              s_wen,
  input  logic              s_rsp_valid,
  output logic              s_rsp_ready,
  input  logic [DW-1:0]     s_rdata,
  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state, state_nx;
  logic owner;
  logic w;
  logic accept;
  logic [1:0] own_oh;
  assign accept = state == IDLE && |m_req_valid;
  assign own_oh = owner ? 2'b10 : 2'b01;
  assign m_rdata = s_rdata;
`ifdef MEM_ARB_RR_EN
  logic rr;
  assign w = &m_req_valid ? ~rr : m_req_valid[1];
  // remember the last winner so a contended request goes to the other master
  always_ff @(posedge clk)
    if (!rst_n) rr <= 1'b0;
    else if (accept) rr <= w;
`else
  assign w = m_req_valid[1];
`endif
  // state, owner and latched request payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wmask <= '0;
      s_wen   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner   <= w;
        s_addr  <= m_addr[w*AW +: AW];
        s_wdata <= m_wdata[w*DW +: DW];
        s_wmask <= m_wmask[w*(DW/8) +: DW/8];
        s_wen   <= m_wen[w];
      end
    end
  end
  // next state and handshake outputs; everything is held low while in reset
  always_comb begin
    state_nx    = state == IDLE ? (|m_req_valid ? REQ : IDLE) :
                  state == REQ  ? (s_req_ready ? RSP : REQ) :
                                  (s_rsp_valid && s_rsp_ready ? IDLE : RSP);
    m_req_ready = rst_n && accept ? (w ? 2'b10 : 2'b01) : 2'b00;
    s_req_valid = rst_n && state == REQ;
    s_rsp_ready = rst_n && state == RSP && m_rsp_ready[owner];
    m_rsp_valid = rst_n && state == RSP && s_rsp_valid ? own_oh : 2'b00;
    grant       = rst_n && state != IDLE ? own_oh : 2'b00;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, handshake timing, stalls and reset
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req_valid, m_req_ready, m_wen, m_rsp_valid, m_rsp_ready, grant;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_req_valid, s_req_ready, s_wen, s_rsp_valid, s_rsp_ready;
  int checks = 0, errors = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wen(m_wen),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rdata(m_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wen(s_wen),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rdata(s_rdata),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; m_req_valid = '0; m_addr = '0; m_wdata = '0; m_wmask = '0; m_wen = '0;
    m_rsp_ready = '0; s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rdata = '0;
    repeat (2) step;
    #1;
    chk("rst_req_ready", m_req_ready, 2'b00);
    chk("rst_s_req_valid", s_req_valid, 1'b0);
    chk("rst_rsp_valid", m_rsp_valid, 2'b00);
    chk("rst_s_rsp_ready", s_rsp_ready, 1'b0);
    chk("rst_grant", grant, 2'b00);
    rst_n = 1'b1;
    step;
    // IFU-only read with a zero-wait memory
    s_req_ready = 1'b1; s_rsp_valid = 1'b1; s_rdata = 32'h0000_0413; m_rsp_ready = 2'b11;
    m_req_valid = 2'b01; m_addr[31:0] = 32'h8000_0000;
    #1;
    chk("t1_c0_ready", m_req_ready, 2'b01);
    chk("t1_c0_grant", grant, 2'b00);
    step;
    m_req_valid = 2'b00;
    #1;
    chk("t1_c1_s_valid", s_req_valid, 1'b1);
    chk("t1_c1_s_addr", s_addr, 32'h8000_0000);
    chk("t1_c1_grant", grant, 2'b01);
    chk("t1_c1_no_rsp_ack", s_rsp_ready, 1'b0);
    step;
    #1;
    chk("t1_c2_rsp_valid", m_rsp_valid, 2'b01);
    chk("t1_c2_rdata", m_rdata, 32'h0000_0413);
    chk("t1_c2_s_rsp_ready", s_rsp_ready, 1'b1);
    step;
    m_req_valid = 2'b01; m_addr[31:0] = 32'h8000_0004;
    #1;
    chk("t1_c3_next_accept", m_req_ready, 2'b01);
    step;
    m_req_valid = 2'b00;
    step;
    step;
    // simultaneous IFU read and LSU write: LSU first, IFU stays pending
    m_req_valid = 2'b11; m_addr = {32'h8000_1000, 32'h8000_0004};
    m_wdata = {32'hDEAD_BEEF, 32'h0}; m_wmask = 8'hF0; m_wen = 2'b10;
    #1;
    chk("t2_both_ready", m_req_ready, 2'b10);
    step;
    m_req_valid = 2'b01;
    #1;
    chk("t2_lsu_wen", s_wen, 1'b1);
    chk("t2_lsu_addr", s_addr, 32'h8000_1000);
    chk("t2_lsu_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("t2_lsu_wmask", s_wmask, 4'hF);
    chk("t2_lsu_grant", grant, 2'b10);
    chk("t2_ifu_pending", m_req_ready, 2'b00);
    step;
    #1;
    chk("t2_lsu_rsp", m_rsp_valid, 2'b10);
    step;
    #1;
    chk("t2_ifu_ready", m_req_ready, 2'b01);
    step;
    m_req_valid = 2'b00; m_wen = 2'b00;
    #1;
    chk("t2_ifu_addr", s_addr, 32'h8000_0004);
    chk("t2_ifu_wen", s_wen, 1'b0);
    step;
    step;
    // downstream stalls request acceptance for 5 cycles
    s_req_ready = 1'b0; m_req_valid = 2'b01; m_addr[31:0] = 32'h8000_0008;
    step;
    m_req_valid = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_s_valid", s_req_valid, 1'b1);
      chk("t3_s_addr", s_addr, 32'h8000_0008);
      chk("t3_no_ready", m_req_ready, 2'b00);
      step;
    end
    s_req_ready = 1'b1;
    step;
    // owner withholds response ready for 3 cycles
    m_req_valid = 2'b00; m_rsp_ready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_s_rsp_ready", s_rsp_ready, 1'b0);
      chk("t4_rsp_valid", m_rsp_valid, 2'b01);
      chk("t4_grant", grant, 2'b01);
      step;
    end
    // reset while in RSP aborts the transaction
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    #1;
    chk("t5_grant", grant, 2'b00);
    chk("t5_s_valid", s_req_valid, 1'b0);
    chk("t5_rsp_valid", m_rsp_valid, 2'b00);
    chk("t5_s_rsp_ready", s_rsp_ready, 1'b0);
    chk("t5_s_addr", s_addr, 32'h0);
    m_req_valid = 2'b01; m_addr[31:0] = 32'h8000_000C; m_rsp_ready = 2'b11;
    #1;
    chk("t5_fresh_ready", m_req_ready, 2'b01);
    step;
    m_req_valid = 2'b00;
    #1;
    chk("t5_fresh_addr", s_addr, 32'h8000_000C);
    step;
    #1;
    chk("t5_fresh_rsp", m_rsp_valid, 2'b01);
    step;
    // both masters request continuously for 10 transactions
    m_req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef MEM_ARB_RR_EN
      chk("t6_arb", m_req_ready, i % 2 == 0 ? 2'b10 : 2'b01);
`else
      chk("t6_arb", m_req_ready, 2'b10);
`endif
      step;
      step;
      step;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
